// File: rtl/cajero_pkg.sv
// Shared constants and types for the teller-machine input path.
package cajero_pkg;

  localparam int unsigned N_BTN = 4;
  localparam int unsigned N_CAS = 4;
  localparam int unsigned SW_W  = 12;

  localparam int unsigned BTN_OK  = 0;
  localparam int unsigned BTN_ADD = 1;
  localparam int unsigned BTN_SUB = 2;
  localparam int unsigned BTN_RST = 3;

  // 10 ms / 20 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF  = 1_000_000;
  localparam int unsigned SW_SETTLE_CYCLES_DEF = 2_000_000;

  typedef logic [SW_W-1:0] sw_word_t;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge pulses.
module debounce_ch
  import cajero_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Count cycles of disagreement; accept the new level after a full stable run
  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      lvl_d  = sync_q;
      rise_d = sync_q;
      fall_d = ~sync_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync_q  <= sync1_q;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/cajero_input_cond.sv
// Input conditioning for the teller controller: debounced buttons and slot sensors,
// plus settle-filtered amount switches with change notification.
module cajero_input_cond
  import cajero_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SW_SETTLE_CYCLES = SW_SETTLE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      button_raw,
  input  logic [3:0]      casillas_raw,
  input  logic [11:0]     in_switch_raw,
  output logic [3:0]      button_lvl,
  output logic [3:0]      button_press,
  output logic [3:0]      casillas_lvl,
  output logic [3:0]      casillas_chg,
  output logic [11:0]     sw_value,
  output logic            sw_stable,
  output logic            sw_update
);

  localparam int unsigned SCNT_W = $clog2(SW_SETTLE_CYCLES);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SW_SETTLE_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SCNT_ACC  = SCNT_W'(SW_SETTLE_CYCLES - 2);

  logic [N_BTN-1:0] btn_fall;
  logic [N_CAS-1:0] cas_rise;
  logic [N_CAS-1:0] cas_fall;
  logic             unused_btn_fall;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (button_raw[i]),
      .lvl  (button_lvl[i]),
      .rise (button_press[i]),
      .fall (btn_fall[i])
    );
  end

  for (genvar i = 0; i < int'(N_CAS); i++) begin : g_cas
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (casillas_raw[i]),
      .lvl  (casillas_lvl[i]),
      .rise (cas_rise[i]),
      .fall (cas_fall[i])
    );
  end

  // Slot sensors report both edges; button releases are not of interest to the controller
  assign casillas_chg    = cas_rise | cas_fall;
  assign unused_btn_fall = ^btn_fall;

  sw_word_t          sw_sync1_q, sw_sync_q;
  sw_word_t          cand_q, cand_d;
  sw_word_t          sw_value_q, sw_value_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              sw_stable_q, sw_stable_d;
  logic              sw_update_q, sw_update_d;

  // Restart the settle window on any bus movement; accept once the window fills
  always_comb begin
    cand_d      = cand_q;
    scnt_d      = scnt_q;
    sw_value_d  = sw_value_q;
    sw_stable_d = sw_stable_q;
    sw_update_d = 1'b0;
    if (sw_sync_q != cand_q) begin
      cand_d      = sw_sync_q;
      scnt_d      = '0;
      sw_stable_d = 1'b0;
    end else if (scnt_q != SCNT_LAST) begin
      scnt_d = scnt_q + SCNT_W'(1);
      if (scnt_q == SCNT_ACC) begin
        sw_value_d  = cand_q;
        sw_stable_d = 1'b1;
        sw_update_d = (cand_q != sw_value_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1_q  <= '0;
      sw_sync_q   <= '0;
      cand_q      <= '0;
      scnt_q      <= '0;
      sw_value_q  <= '0;
      sw_stable_q <= 1'b0;
      sw_update_q <= 1'b0;
    end else begin
      sw_sync1_q  <= in_switch_raw;
      sw_sync_q   <= sw_sync1_q;
      cand_q      <= cand_d;
      scnt_q      <= scnt_d;
      sw_value_q  <= sw_value_d;
      sw_stable_q <= sw_stable_d;
      sw_update_q <= sw_update_d;
    end
  end

  assign sw_value  = sw_value_q;
  assign sw_stable = sw_stable_q;
  assign sw_update = sw_update_q;

endmodule

// File: tb/tb_cajero_input_cond.sv
// Bench for cajero_input_cond: directed scenarios plus random stimulus against a
// history-window reference model.
module tb_cajero_input_cond;
  import cajero_pkg::*;

  localparam int unsigned D = 4;
  localparam int          S = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  button_raw = '0;
  logic [3:0]  casillas_raw = '0;
  logic [11:0] in_switch_raw = '0;
  logic [3:0]  button_lvl, button_press, casillas_lvl, casillas_chg;
  logic [11:0] sw_value;
  logic        sw_stable, sw_update;

  cajero_input_cond #(
    .DEBOUNCE_CYCLES (D),
    .SW_SETTLE_CYCLES(S)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_raw   (button_raw),
    .casillas_raw (casillas_raw),
    .in_switch_raw(in_switch_raw),
    .button_lvl   (button_lvl),
    .button_press (button_press),
    .casillas_lvl (casillas_lvl),
    .casillas_chg (casillas_chg),
    .sw_value     (sw_value),
    .sw_stable    (sw_stable),
    .sw_update    (sw_update)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a channel flips when its synchronised samples over the last D
  // cycles all disagree with the current level; the switch bus is accepted when its
  // synchronised value has been held for exactly S consecutive samples.
  logic [19:0] m_s1, m_s;
  logic [7:0]  dwin[$];
  logic [7:0]  e_lvl, e_pls;
  logic [11:0] e_swv, prev_sw;
  int          run;
  logic        e_stab, e_upd;

  task automatic model_reset();
    m_s1 = '0;
    m_s  = '0;
    dwin.delete();
    for (int i = 0; i < int'(D); i++) dwin.push_back(8'h00);
    e_lvl   = '0;
    e_pls   = '0;
    e_swv   = '0;
    prev_sw = '0;
    run     = 1;
    e_stab  = 1'b0;
    e_upd   = 1'b0;
  endtask

  task automatic model_edge();
    logic [19:0] sb;
    logic        flip;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sb   = m_s;
    m_s  = m_s1;
    m_s1 = {in_switch_raw, casillas_raw, button_raw};
    dwin.push_back(sb[7:0]);
    void'(dwin.pop_front());
    e_pls = '0;
    for (int c = 0; c < 8; c++) begin
      flip = 1'b1;
      foreach (dwin[k]) if (dwin[k][c] == e_lvl[c]) flip = 1'b0;
      if (flip) begin
        e_lvl[c] = ~e_lvl[c];
        e_pls[c] = (c < 4) ? e_lvl[c] : 1'b1;
      end
    end
    e_upd = 1'b0;
    if (sb[19:8] == prev_sw) begin
      if (run < S) begin
        run++;
        if (run == S) begin
          e_upd = (sb[19:8] != e_swv);
          e_swv = sb[19:8];
        end
      end
    end else begin
      run     = 1;
      prev_sw = sb[19:8];
    end
    e_stab = (run == S);
  endtask

  task automatic compare_all();
    check("button_lvl",   32'(button_lvl),   32'(e_lvl[3:0]));
    check("button_press", 32'(button_press), 32'(e_pls[3:0]));
    check("casillas_lvl", 32'(casillas_lvl), 32'(e_lvl[7:4]));
    check("casillas_chg", 32'(casillas_chg), 32'(e_pls[7:4]));
    check("sw_value",     32'(sw_value),     32'(e_swv));
    check("sw_stable",    32'(sw_stable),    32'(e_stab));
    check("sw_update",    32'(sw_update),    32'(e_upd));
  endtask

  task automatic cycle(input logic [3:0] b, input logic [3:0] c, input logic [11:0] sw,
                       input logic rn);
    @(negedge clk);
    button_raw    = b;
    casillas_raw  = c;
    in_switch_raw = sw;
    rst_n         = rn;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0]  rb, rc, gb, gc;
  logic [11:0] rsw;
  logic        rn, saw_low;
  int          hold_b, hold_s;
  logic [4:0]  bseq;

  initial begin
    // Reset with every raw input high
    #2;
    rst_n         = 1'b0;
    button_raw    = 4'hF;
    casillas_raw  = 4'hF;
    in_switch_raw = 12'hFFF;
    model_reset();
    #1;
    check("rst_levels", 32'({button_lvl, casillas_lvl}), 32'h0);
    check("rst_pulses", 32'({button_press, casillas_chg, sw_update, sw_stable}), 32'h0);
    check("rst_sw_value", 32'(sw_value), 32'h0);
    for (int k = 0; k < 3; k++) cycle(4'hF, 4'hF, 12'hFFF, 1'b0);

    // Release with confirm held: fresh transition, pulse 5 edges after first sample
    for (int k = 1; k <= 8; k++) begin
      cycle(4'b0001, 4'h0, 12'h000, 1'b1);
      check("rel_press0", 32'(button_press[0]), 32'(k == 6));
      check("rel_lvl0", 32'(button_lvl[0]), 32'(k >= 6));
    end

    // Bounce on add button, then hold
    bseq = 5'b01101;
    for (int k = 1; k <= 15; k++) begin
      cycle({2'b00, (k <= 5) ? bseq[k-1] : 1'b1, 1'b1}, 4'h0, 12'h000, 1'b1);
      check("bounce_press1", 32'(button_press[1]), 32'(k == 11));
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(4'b0001, 4'h0, 12'h000, 1'b1);
      check("release_press1", 32'(button_press[1]), 32'h0);
    end
    check("release_lvl1", 32'(button_lvl[1]), 32'h0);

    // Simultaneous presses on withdraw and reset buttons
    for (int k = 1; k <= 8; k++) begin
      cycle(4'b1101, 4'h0, 12'h000, 1'b1);
      check("simul_press", 32'(button_press[3:2]), (k == 6) ? 32'h3 : 32'h0);
    end
    for (int k = 1; k <= 10; k++) cycle(4'b0000, 4'h0, 12'h000, 1'b1);
    check("simul_released", 32'(button_lvl), 32'h0);

    // Casilla 0 rises, held 10 cycles, then falls
    for (int k = 1; k <= 20; k++) begin
      cycle(4'h0, {3'b000, k <= 10}, 12'h000, 1'b1);
      check("cas_chg0", 32'(casillas_chg[0]), 32'((k == 6) || (k == 16)));
    end

    // Switch bus settles to 12
    for (int k = 1; k <= 14; k++) begin
      cycle(4'h0, 4'h0, 12'h00C, 1'b1);
      check("sw_upd_12", 32'(sw_update), 32'(k == 10));
    end
    check("sw_val_12", 32'(sw_value), 32'h00C);
    check("sw_stab_12", 32'(sw_stable), 32'h1);

    // Brief excursion to 1000 and back: no update, stability dips
    saw_low = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cycle(4'h0, 4'h0, (k <= 3) ? 12'h3E8 : 12'h00C, 1'b1);
      check("sw_glitch_upd", 32'(sw_update), 32'h0);
      check("sw_glitch_val", 32'(sw_value), 32'h00C);
      if (!sw_stable) saw_low = 1'b1;
    end
    check("sw_glitch_dip", 32'(saw_low), 32'h1);
    check("sw_glitch_stab", 32'(sw_stable), 32'h1);

    // Reset mid-debounce of confirm, counter at 2
    for (int k = 1; k <= 4; k++) cycle(4'b0001, 4'h0, 12'h00C, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_lvl0", 32'(button_lvl[0]), 32'h0);
    check("midrst_swval", 32'(sw_value), 32'h0);
    for (int k = 0; k < 2; k++) cycle(4'b0001, 4'h0, 12'h00C, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'b0001, 4'h0, 12'h00C, 1'b1);
      check("midrst_press0", 32'(button_press[0]), 32'(k == 6));
    end

    // Random segments with glitches and occasional resets
    hold_b = 0;
    hold_s = 0;
    rb = '0; rc = '0; rsw = '0;
    for (int t = 0; t < 3000; t++) begin
      if (hold_b == 0) begin
        rb     = 4'($urandom);
        rc     = 4'($urandom);
        hold_b = int'($urandom_range(1, 12));
      end
      if (hold_s == 0) begin
        rsw    = 12'($urandom);
        hold_s = int'($urandom_range(1, 16));
      end
      gb = rb;
      gc = rc;
      if ($urandom_range(0, 9) == 0) gb[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) gc[$urandom_range(0, 3)] ^= 1'b1;
      rn = ($urandom_range(0, 499) != 0);
      cycle(gb, gc, rsw, rn);
      hold_b--;
      hold_s--;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cajero_input_cond.md
# cajero_input_cond

Input-conditioning stage directly upstream of the teller-machine controller. It synchronises the raw board buttons, the four cash-slot ("casillas") sensors and the 12 amount switches into the `clk` domain. It debounces each line and delivers clean levels plus single-cycle press and change pulses. The controller can then act on one event per physical press instead of sampling bouncing inputs for millions of cycles.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button or casilla level changes (10 ms at 100 MHz).
- `SW_SETTLE_CYCLES`, default 2_000_000: consecutive unchanged cycles required before a new switch value is accepted (20 ms).
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `button_raw`  in  4  raw buttons: [0] confirm, [1] add, [2] withdraw, [3] reset.
- `casillas_raw`  in  4  raw cash-slot sensors.
- `in_switch_raw`  in  12  raw amount/password switches.
- `button_lvl`  out  4  debounced button levels.
- `button_press`  out  4  one-cycle pulse on each debounced 0→1 of `button_lvl`.
- `casillas_lvl`  out  4  debounced slot levels.
- `casillas_chg`  out  4  one-cycle pulse on any debounced transition of `casillas_lvl`.
- `sw_value`  out  12  last accepted (settled) switch value.
- `sw_stable`  out  1  high while the synchronised switch bus equals `sw_value` and has settled.
- `sw_update`  out  1  one-cycle pulse when `sw_value` takes a different value.

## Operation
- Synchronisation: every raw bit passes through two flops. The flop outputs reset to 0.
- Debounce, 8 independent channels (4 buttons, 4 casillas). Each channel behaves as follows:
  - Counter `cnt` counts cycles where the synchronised bit `s` ≠ `lvl`.
  - When `s` = `lvl`, `cnt` clears to 0.
  - On the cycle `cnt` reaches `DEBOUNCE_CYCLES-1` with `s` ≠ `lvl`: `lvl` ← `s`, `cnt` ← 0, and the edge pulse asserts for exactly that one cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no output change and no pulse.
- Simultaneous presses on several channels: each channel pulses independently. No priority and no suppression; the controller arbitrates.
- Switch settling:
  - Register `cand` (12 b) and counter `scnt`.
  - If the synchronised bus ≠ `cand`: `cand` ← bus, `scnt` ← 0, `sw_stable` ← 0.
  - Otherwise `scnt` increments, saturating at `SW_SETTLE_CYCLES-1`.
  - On the cycle `scnt` reaches `SW_SETTLE_CYCLES-1`: `sw_value` ← `cand` and `sw_stable` ← 1. `sw_update` pulses only if `cand` ≠ the previous `sw_value`.
  - `sw_value` holds its last accepted value while the bus is moving.
- Counters never wrap. `cnt` clears on acceptance; `scnt` saturates.

## Timing
- Reset values: all sync flops, counters, `cand`, `button_lvl`, `casillas_lvl`, `sw_value` = 0. `button_press`, `casillas_chg`, `sw_update`, `sw_stable` = 0.
- Debounce latency: raw change held stable is sampled on edge N. The `lvl` change and its pulse are visible after edge N+1+`DEBOUNCE_CYCLES`.
- Switch latency: a bus change sampled on edge N sets `sw_value`, `sw_stable` and `sw_update` after edge N+1+`SW_SETTLE_CYCLES`.
- Pulses are exactly one cycle wide. A held input never re-pulses.
- Reset asserted mid-debounce: the counter is lost and outputs drop to 0 immediately.
- Input held through reset release: treated as a fresh transition. `button_press` fires after the full latency.
- Minimum legal parameter value is 2 for both parameters.

## Structure
- Shared package `cajero_pkg` holds the following:
  - Constants `N_BTN=4`, `N_CAS=4`, `SW_W=12`.
  - Button index constants `BTN_OK=0`, `BTN_ADD=1`, `BTN_SUB=2`, `BTN_RST=3`.
  - Default cycle counts.
- Sub-module `debounce_ch` is parameterised by `DEBOUNCE_CYCLES`. Ports: `clk`, `rst_n`, `raw`, `lvl`, `rise`, `fall`. It contains its own 2-flop synchroniser. It is instantiated 8 times; `casillas_chg` = `rise | fall`.
- Switch settle logic stays in the top level. Counter widths use `$clog2(param)`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `SW_SETTLE_CYCLES=8`.
- Reset: `rst_n`=0 with all raw inputs high → all outputs 0. Release with `button_raw[0]` held → `button_lvl[0]`=1 and exactly one `button_press[0]` pulse, 5 edges after the first sample.
- Bounce: `button_raw[1]` toggles 1,0,1,1,0 (1 cycle each), then holds 1 → no pulse during the toggling. One pulse 5 edges after the final rising sample. Release → no press pulse.
- Simultaneous: `button_raw[2]` and `button_raw[3]` rise on the same cycle → both `button_press` bits pulse on the same cycle.
- Casilla: `casillas_raw[0]` 0→1, held 10 cycles, then →0 → two `casillas_chg[0]` pulses, 5 edges after each edge.
- Switches:
  - Bus 0→0x00C (12 decimal) held → `sw_value`=0x00C, `sw_stable`=1 and one `sw_update` pulse after 9 edges.
  - Bus changes 0x00C→0x3E8 (1000), back to 0x00C within 5 cycles, then holds → no `sw_update`, `sw_value` stays 0x00C, `sw_stable` dips low then returns high.
- Mid-operation reset: `rst_n` pulsed low while `button_raw[0]` counter=2 → `lvl` stays 0. After release, the full 5-edge latency restarts.
